// File: rtl/hub75_monitor_pkg.sv
// hub75_monitor_pkg
//   Shared types, error-bit indices and width helpers for the HUB75 scan
//   monitor. The helpers are constant functions so they can size ports and
//   counters from the module parameters.
package hub75_monitor_pkg;

    typedef enum logic {
        S_SYNC = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Bit positions inside the sticky err vector
    localparam int ERR_SHIFT   = 0;
    localparam int ERR_ROWSEQ  = 1;
    localparam int ERR_OELATCH = 2;
    localparam int ERR_STALL   = 3;
    localparam int ERR_W       = 4;

    // Ceiling log2, returns 0 for v <= 1
    function automatic int clog2_f(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Pixel counter needs headroom above PIXEL_WIDTH so an over-long row is
    // still distinguishable from a correct one before saturating.
    function automatic int pix_cnt_w(input int pixel_width);
        return clog2_f(pixel_width) + 2;
    endfunction

    function automatic int idle_cnt_w(input int stall_timeout);
        return clog2_f(stall_timeout) + 1;
    endfunction

endpackage

// File: rtl/hub75_edge_sampler.sv
// hub75_edge_sampler
//   Registers N asynchronous-to-nothing (already clk_in synchronous) bus bits
//   twice and produces a one-cycle rising-edge pulse per bit.
// Ports
//   clk_in  in   1  sampling clock
//   reset   in   1  asynchronous, active-high
//   d_i     in   N  raw bus bits
//   s_o     out  N  first-stage sample
//   rise_o  out  N  s & ~p, high for the cycle a bit is first seen high
module hub75_edge_sampler #(
    parameter int N = 1
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] s_o,
    output logic [N-1:0] rise_o
);

    logic [N-1:0] s_q;
    logic [N-1:0] p_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            s_q <= '0;
            p_q <= '0;
        end else begin
            s_q <= d_i;
            p_q <= s_q;
        end
    end

    assign s_o    = s_q;
    assign rise_o = s_q & ~p_q;

endmodule

// File: rtl/hub75_scan_monitor.sv
// hub75_scan_monitor
//   Receive-side monitor for a HUB75 scan bus. Rebuilds the row/frame
//   sequence, measures shift edges and OE-on cycles per row and raises
//   sticky protocol errors.
// Ports
//   clk_in            in   1    system clock, bus is synchronous to it
//   reset             in   1    asynchronous, active-high
//   clk_pixel         in   1    HUB75 shift clock
//   row_latch         in   1    HUB75 latch
//   output_enable     in   1    HUB75 OE (polarity by OE_ACTIVE_LOW)
//   row_address       in   4    HUB75 A..D
//   err_clear         in   1    pulse, clears err
//   latch_strobe      out  1    pulse when a row result is published
//   last_row          out  4    row address at latest latch
//   last_pixel_count  out  CW   shift edges in latest row (saturating)
//   last_on_cycles    out  ONW  OE-active cycles in latest row (saturating)
//   frame_count       out  16   row wraps to 0
//   synced            out  1    first latch seen and no stall since
//   err               out  4    sticky errors, see ERR_* in the package
module hub75_scan_monitor
    import hub75_monitor_pkg::*;
#(
    parameter int  PIXEL_WIDTH      = 64,
    parameter int  PIXEL_HALFHEIGHT = 16,
    parameter bit  OE_ACTIVE_LOW    = 1'b1,
    parameter int  STALL_TIMEOUT    = 2**20,
    parameter int  ON_CYCLES_WIDTH  = 24,
    localparam int CW               = pix_cnt_w(PIXEL_WIDTH)
) (
    input  logic                       clk_in,
    input  logic                       reset,
    input  logic                       clk_pixel,
    input  logic                       row_latch,
    input  logic                       output_enable,
    input  logic [3:0]                 row_address,
    input  logic                       err_clear,
    output logic                       latch_strobe,
    output logic [3:0]                 last_row,
    output logic [CW-1:0]              last_pixel_count,
    output logic [ON_CYCLES_WIDTH-1:0] last_on_cycles,
    output logic [15:0]                frame_count,
    output logic                       synced,
    output logic [ERR_W-1:0]           err
);

    localparam int              IW        = idle_cnt_w(STALL_TIMEOUT);
    localparam logic [IW-1:0]   IDLE_LAST = IW'(STALL_TIMEOUT - 1);
    localparam logic [CW-1:0]   PIX_EXP   = CW'(PIXEL_WIDTH);
    localparam logic [3:0]      ROW_LAST  = 4'(PIXEL_HALFHEIGHT - 1);

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic [2:0] bus_s;
    logic [2:0] bus_rise;
    logic [3:0] row_s_q;

    hub75_edge_sampler #(.N(3)) u_sampler (
        .clk_in (clk_in),
        .reset  (reset),
        .d_i    ({clk_pixel, row_latch, output_enable}),
        .s_o    (bus_s),
        .rise_o (bus_rise)
    );

    // Row address is only ever looked at on a latch edge, one stage suffices
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) row_s_q <= '0;
        else       row_s_q <= row_address;
    end

    logic pix_rise;
    logic latch_rise;
    logic latch_s;
    logic oe_s;
    logic oe_act;

    assign pix_rise   = bus_rise[2];
    assign latch_rise = bus_rise[1];
    assign latch_s    = bus_s[1];
    assign oe_s       = bus_s[0];
    assign oe_act     = OE_ACTIVE_LOW ? ~oe_s : oe_s;

    // Level of clk_pixel and the OE edge are not needed by the monitor
    logic unused_bus;
    assign unused_bus = ^{bus_s[2], bus_rise[0]};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                     state_q,     state_d;
    logic [CW-1:0]              pix_cnt_q,   pix_cnt_d;
    logic [ON_CYCLES_WIDTH-1:0] on_cnt_q,    on_cnt_d;
    logic [IW-1:0]              idle_cnt_q,  idle_cnt_d;
    logic [3:0]                 last_row_q,  last_row_d;
    logic [CW-1:0]              last_pix_q,  last_pix_d;
    logic [ON_CYCLES_WIDTH-1:0] last_on_q,   last_on_d;
    logic [15:0]                frame_q,     frame_d;
    logic                       synced_q,    synced_d;
    logic                       strobe_q,    strobe_d;
    logic [ERR_W-1:0]           err_q,       err_d;
    logic [ERR_W-1:0]           new_err;
    logic [3:0]                 row_next;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= S_SYNC;
            pix_cnt_q  <= '0;
            on_cnt_q   <= '0;
            idle_cnt_q <= '0;
            last_row_q <= '0;
            last_pix_q <= '0;
            last_on_q  <= '0;
            frame_q    <= '0;
            synced_q   <= 1'b0;
            strobe_q   <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            on_cnt_q   <= on_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            last_row_q <= last_row_d;
            last_pix_q <= last_pix_d;
            last_on_q  <= last_on_d;
            frame_q    <= frame_d;
            synced_q   <= synced_d;
            strobe_q   <= strobe_d;
            err_q      <= err_d;
        end
    end

    assign row_next = (last_row_q == ROW_LAST) ? 4'd0 : last_row_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        on_cnt_d   = on_cnt_q;
        idle_cnt_d = idle_cnt_q;
        last_row_d = last_row_q;
        last_pix_d = last_pix_q;
        last_on_d  = last_on_q;
        frame_d    = frame_q;
        synced_d   = synced_q;
        strobe_d   = 1'b0;
        new_err    = '0;

        // OE must be dark while the latch is high, regardless of sync state
        if (latch_s && oe_act) new_err[ERR_OELATCH] = 1'b1;

        case (state_q)
            S_SYNC: begin
                pix_cnt_d  = '0;
                on_cnt_d   = '0;
                idle_cnt_d = '0;
                if (latch_rise) begin
                    state_d    = S_RUN;
                    synced_d   = 1'b1;
                    last_row_d = row_s_q;
                    // a shift edge coincident with the latch opens the new row
                    pix_cnt_d  = CW'(pix_rise);
                end
            end

            S_RUN: begin
                if (latch_rise) begin
                    last_pix_d = pix_cnt_q;
                    last_on_d  = on_cnt_q;
                    last_row_d = row_s_q;
                    strobe_d   = 1'b1;
                    pix_cnt_d  = CW'(pix_rise);
                    on_cnt_d   = '0;
                    idle_cnt_d = '0;
                    if (pix_cnt_q != PIX_EXP) new_err[ERR_SHIFT]  = 1'b1;
                    if (row_s_q != row_next)  new_err[ERR_ROWSEQ] = 1'b1;
                    if (row_s_q == 4'd0 && last_row_q == ROW_LAST)
                        frame_d = frame_q + 16'd1;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d    = S_SYNC;
                    synced_d   = 1'b0;
                    pix_cnt_d  = '0;
                    on_cnt_d   = '0;
                    idle_cnt_d = '0;
                    new_err[ERR_STALL] = 1'b1;
                end else begin
                    if (pix_rise && pix_cnt_q != '1)
                        pix_cnt_d = pix_cnt_q + CW'(1);
                    if (oe_act && on_cnt_q != '1)
                        on_cnt_d = on_cnt_q + ON_CYCLES_WIDTH'(1);
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end
            end
        endcase

        // An error arriving with the clear pulse survives the clear
        err_d = (err_clear ? '0 : err_q) | new_err;
    end

    assign latch_strobe     = strobe_q;
    assign last_row         = last_row_q;
    assign last_pixel_count = last_pix_q;
    assign last_on_cycles   = last_on_q;
    assign frame_count      = frame_q;
    assign synced           = synced_q;
    assign err              = err_q;

endmodule

// File: tb/tb_hub75_scan_monitor.sv
// Bench for hub75_scan_monitor: a bus driver emulating the scan source pushes
// the expected row result into a queue at each latch; a monitor pops and
// compares on every latch_strobe.
module tb_hub75_scan_monitor;

    // Stall window is larger than one 64-pixel row (130 cycles) and than the
    // 260-edge saturation row, so only the deliberate idle period stalls.
    localparam int STALL = 1000;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic        clk_pixel = 1'b0;
    logic        row_latch = 1'b0;
    logic        output_enable = 1'b1;
    logic [3:0]  row_address = '0;
    logic        err_clear = 1'b0;
    logic        latch_strobe;
    logic [3:0]  last_row;
    logic [7:0]  last_pixel_count;
    logic [23:0] last_on_cycles;
    logic [15:0] frame_count;
    logic        synced;
    logic [3:0]  err;

    hub75_scan_monitor #(
        .PIXEL_WIDTH      (64),
        .PIXEL_HALFHEIGHT (16),
        .OE_ACTIVE_LOW    (1'b1),
        .STALL_TIMEOUT    (STALL),
        .ON_CYCLES_WIDTH  (24)
    ) u_dut (
        .clk_in           (clk_in),
        .reset            (reset),
        .clk_pixel        (clk_pixel),
        .row_latch        (row_latch),
        .output_enable    (output_enable),
        .row_address      (row_address),
        .err_clear        (err_clear),
        .latch_strobe     (latch_strobe),
        .last_row         (last_row),
        .last_pixel_count (last_pixel_count),
        .last_on_cycles   (last_on_cycles),
        .frame_count      (frame_count),
        .synced           (synced),
        .err              (err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [3:0]  row;
        logic [7:0]  pix;
        logic [23:0] on;
        logic [15:0] frame;
        logic [3:0]  err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    bit         m_synced = 1'b0;
    logic [3:0] m_last   = '0;
    logic [15:0] m_frame = '0;
    logic [3:0] m_err    = '0;
    int         m_carry  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // One row: npix shift edges (2 cycles each) with OE on for the first
    // 'on' cycles, a one-cycle latch, then one quiet cycle.
    task automatic drive_row(input logic [3:0] row, input int npix, input int on,
                             input bit pix_at_latch, input bit oe_at_latch);
        int   cyc;
        int   cnt;
        logic [3:0] eb;
        exp_t e;
        cyc = 0;
        for (int i = 0; i < npix; i++) begin
            clk_pixel = 1'b1; output_enable = (cyc < on) ? 1'b0 : 1'b1; step(); cyc++;
            clk_pixel = 1'b0; output_enable = (cyc < on) ? 1'b0 : 1'b1; step(); cyc++;
        end
        clk_pixel     = pix_at_latch;
        row_latch     = 1'b1;
        row_address   = row;
        output_enable = !oe_at_latch;
        if (!m_synced) begin
            m_synced = 1'b1;
        end else begin
            cnt = npix + m_carry;
            eb  = '0;
            if (cnt != 64) eb[0] = 1'b1;
            if (row != 4'((int'(m_last) + 1) % 16)) eb[1] = 1'b1;
            if (oe_at_latch) eb[2] = 1'b1;
            if (row == 4'd0 && m_last == 4'd15) m_frame = m_frame + 16'd1;
            m_err   = m_err | eb;
            e.row   = row;
            e.pix   = (cnt > 255) ? 8'd255 : 8'(cnt);
            e.on    = 24'(on);
            e.frame = m_frame;
            e.err   = m_err;
            sb.push_back(e);
        end
        m_last  = row;
        m_carry = pix_at_latch ? 1 : 0;
        step();
        row_latch = 1'b0; clk_pixel = 1'b0; output_enable = 1'b1;
        step();
    endtask

    task automatic clear_err();
        err_clear = 1'b1; step();
        err_clear = 1'b0; m_err = '0;
        @(negedge clk_in);
        chk("err_clr", 32'(err), 32'd0);
        step();
    endtask

    always @(negedge clk_in) begin
        if (!reset && latch_strobe) begin
            if (sb.size() == 0) begin
                chk("strobe_unexp", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("row",   32'(last_row),         32'(mon_e.row));
                chk("pix",   32'(last_pixel_count), 32'(mon_e.pix));
                chk("on",    32'(last_on_cycles),   32'(mon_e.on));
                chk("frame", 32'(frame_count),      32'(mon_e.frame));
                chk("err",   32'(err),              32'(mon_e.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset state
        #1;
        chk("rst_strobe", 32'(latch_strobe),     32'd0);
        chk("rst_row",    32'(last_row),         32'd0);
        chk("rst_pix",    32'(last_pixel_count), 32'd0);
        chk("rst_on",     32'(last_on_cycles),   32'd0);
        chk("rst_frame",  32'(frame_count),      32'd0);
        chk("rst_sync",   32'(synced),           32'd0);
        chk("rst_err",    32'(err),              32'd0);
        step(); step();
        reset = 1'b0;
        step();

        // three clean frames; first latch only syncs
        for (int f = 0; f < 3; f++)
            for (int r = 0; r < 16; r++)
                drive_row(4'(r), 64, r * 3 + 1, 1'b0, 1'b0);
        @(negedge clk_in);
        chk("loop_sync",  32'(synced),      32'd1);
        chk("loop_frame", 32'(frame_count), 32'd2);
        chk("loop_err",   32'(err),         32'd0);
        step();

        // short row: 63 edges
        drive_row(4'd0, 63, 5, 1'b0, 1'b0);
        clear_err();

        // row skip 2 -> 4
        drive_row(4'd1, 64, 2, 1'b0, 1'b0);
        drive_row(4'd2, 64, 2, 1'b0, 1'b0);
        drive_row(4'd4, 64, 2, 1'b0, 1'b0);
        clear_err();

        // frame wrap 14,15,0 (14 after 4 is itself a skip)
        drive_row(4'd14, 64, 7, 1'b0, 1'b0);
        clear_err();
        drive_row(4'd15, 64, 7, 1'b0, 1'b0);
        drive_row(4'd0,  64, 7, 1'b0, 1'b0);

        // OE active during latch
        drive_row(4'd1, 64, 9, 1'b0, 1'b1);
        chk("oe_latch", 32'(err), 32'd4);
        clear_err();

        // shift edge coincident with latch counts toward the next row
        drive_row(4'd2, 64, 3, 1'b1, 1'b0);
        drive_row(4'd3, 63, 3, 1'b0, 1'b0);

        // saturation
        drive_row(4'd4, 260, 200, 1'b0, 1'b0);
        clear_err();

        // stall: no latch after row 5
        drive_row(4'd5, 64, 1, 1'b0, 1'b0);
        n = 0;
        while (n < 2 * STALL && !err[3]) begin
            step();
            n++;
        end
        chk("stall_lat",  32'(n),      32'(STALL));
        chk("stall_sync", 32'(synced), 32'd0);
        chk("stall_err",  32'(err),    32'd8);
        m_synced = 1'b0;
        m_carry  = 0;
        m_err    = 4'd8;
        clear_err();

        // re-sync: first latch publishes nothing
        drive_row(4'd7, 64, 4, 1'b0, 1'b0);
        @(negedge clk_in);
        chk("resync", 32'(synced), 32'd1);
        step();
        drive_row(4'd8, 64, 4, 1'b0, 1'b0);
        step(); step();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        // async reset mid-row
        for (int i = 0; i < 10; i++) begin
            clk_pixel = 1'b1; step();
            clk_pixel = 1'b0; step();
        end
        #2 reset = 1'b1;
        #1;
        chk("mid_row",   32'(last_row),         32'd0);
        chk("mid_pix",   32'(last_pixel_count), 32'd0);
        chk("mid_on",    32'(last_on_cycles),   32'd0);
        chk("mid_frame", 32'(frame_count),      32'd0);
        chk("mid_sync",  32'(synced),           32'd0);
        chk("mid_err",   32'(err),              32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
